// File: rtl/result_monitor_pkg.sv
// Shared types and constants for the result_monitor store checker.
package result_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CHECK   = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0100;
    localparam logic [31:0] DEF_DONE_ADDR = 32'h0000_0FFC;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned WORD_W    = LANE_W * NUM_LANES;

endpackage

// File: rtl/result_monitor_byte_merge.sv
// Per-byte-lane merge of a new store into an existing captured word.
module result_byte_merge
    import result_monitor_pkg::*;
(
    input  logic [WORD_W-1:0]    old_word_i,
    input  logic [WORD_W-1:0]    new_data_i,
    input  logic [NUM_LANES-1:0] wen_i,
    output logic [WORD_W-1:0]    merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (wen_i[k]) begin
                merged_o[k*LANE_W +: LANE_W] = new_data_i[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/result_monitor.sv
// Snoops CPU data-memory stores into a result window and checks them
// against a programmed expected table, reporting pass/fail/timeout.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned NUM_RESULTS    = 6,
    parameter logic [31:0] DONE_ADDR      = DEF_DONE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 300,
    parameter int unsigned IDX_W          = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      d_mem_addr,
    input  logic [31:0]      d_mem_wdata,
    input  logic [3:0]       d_mem_wen,
    input  logic             exp_wr_en,
    input  logic [IDX_W-1:0] exp_wr_idx,
    input  logic [31:0]      exp_wr_data,
    input  logic             start,
    input  logic             clear,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx,
    output logic             timeout,
    output logic             misaligned_err,
    output logic [15:0]      cycle_count
);

    localparam logic [31:0]            WIN_END   = BASE_ADDR + 32'(4 * NUM_RESULTS);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_RESULTS - 1);
    localparam logic [NUM_RESULTS-1:0] ALL_VALID = '1;

    state_e                 state_q, state_d;
    logic [31:0]            cap_q [NUM_RESULTS];
    logic [31:0]            exp_q [NUM_RESULTS];
    logic [NUM_RESULTS-1:0] valid_q, valid_d;
    logic [15:0]            cycle_q, cycle_d;
    logic [IDX_W-1:0]       chk_idx_q, chk_idx_d;
    logic [IDX_W-1:0]       fail_idx_q, fail_idx_d;
    logic                   mis_q, mis_d;
    logic                   done_q, pass_q, timeout_q;

    logic             wr_any, in_win, aligned, done_hit, cap_we, mismatch;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      merged;

    assign wr_any   = |d_mem_wen;
    assign in_win   = wr_any && (d_mem_addr >= BASE_ADDR) && (d_mem_addr < WIN_END);
    assign aligned  = (d_mem_addr[1:0] == 2'b00);
    assign wr_idx   = IDX_W'((d_mem_addr - BASE_ADDR) >> 2);
    assign done_hit = wr_any && (d_mem_addr[31:2] == DONE_ADDR[31:2]);
    assign cap_we   = !clear && (state_q == ST_RUN) && in_win && aligned;
    assign mismatch = !valid_q[chk_idx_q] || (cap_q[chk_idx_q] != exp_q[chk_idx_q]);

    result_byte_merge u_merge (
        .old_word_i (cap_q[wr_idx]),
        .new_data_i (d_mem_wdata),
        .wen_i      (d_mem_wen),
        .merged_o   (merged)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cycle_d    = cycle_q;
        chk_idx_d  = chk_idx_q;
        fail_idx_d = fail_idx_q;
        mis_d      = mis_q;
        if (clear) begin
            state_d    = ST_IDLE;
            valid_d    = '0;
            cycle_d    = '0;
            fail_idx_d = '0;
            mis_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        valid_d = '0;
                        cycle_d = '0;
                    end
                end
                ST_RUN: begin
                    if (cycle_q != '1) cycle_d = cycle_q + 16'd1;
                    if (in_win && !aligned) mis_d = 1'b1;
                    if (cap_we) valid_d[wr_idx] = 1'b1;
                    chk_idx_d = '0;
                    // Current store is folded in first, so a check trigger beats a coincident timeout.
                    if ((valid_d == ALL_VALID) || done_hit) begin
                        state_d = ST_CHECK;
                    end else if (32'(cycle_d) >= TIMEOUT_CYCLES) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_idx_d = chk_idx_q;
                        state_d    = ST_FAIL;
                    end else if (chk_idx_q == LAST_IDX) begin
                        state_d = ST_PASS;
                    end else begin
                        chk_idx_d = chk_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            cycle_q    <= '0;
            chk_idx_q  <= '0;
            fail_idx_q <= '0;
            mis_q      <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cycle_q    <= cycle_d;
            chk_idx_q  <= chk_idx_d;
            fail_idx_q <= fail_idx_d;
            mis_q      <= mis_d;
            done_q     <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
            pass_q     <= (state_d == ST_PASS);
            timeout_q  <= (state_d == ST_TIMEOUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_RESULTS; i++) cap_q[i] <= '0;
        end else if (cap_we) begin
            cap_q[wr_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_RESULTS; i++) exp_q[i] <= '0;
        end else if (!clear && (state_q == ST_IDLE) && exp_wr_en && (32'(exp_wr_idx) < NUM_RESULTS)) begin
            exp_q[exp_wr_idx] <= exp_wr_data;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign fail_idx       = fail_idx_q;
    assign misaligned_err = mis_q;
    assign cycle_count    = cycle_q;

endmodule

// File: tb/tb_result_monitor.sv
// Directed scoreboard bench for result_monitor.
module tb_result_monitor;

    localparam int unsigned N    = 6;
    localparam int unsigned TMO  = 300;
    localparam int unsigned IW   = 3;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] DADR = 32'h0000_0FFC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   d_mem_addr = '0;
    logic [31:0]   d_mem_wdata = '0;
    logic [3:0]    d_mem_wen = '0;
    logic          exp_wr_en = 1'b0;
    logic [IW-1:0] exp_wr_idx = '0;
    logic [31:0]   exp_wr_data = '0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          done, pass, timeout, misaligned_err;
    logic [IW-1:0] fail_idx;
    logic [15:0]   cycle_count;

    always #5 clk = ~clk;

    result_monitor #(
        .BASE_ADDR      (BASE),
        .NUM_RESULTS    (N),
        .DONE_ADDR      (DADR),
        .TIMEOUT_CYCLES (TMO),
        .IDX_W          (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .d_mem_addr     (d_mem_addr),
        .d_mem_wdata    (d_mem_wdata),
        .d_mem_wen      (d_mem_wen),
        .exp_wr_en      (exp_wr_en),
        .exp_wr_idx     (exp_wr_idx),
        .exp_wr_data    (exp_wr_data),
        .start          (start),
        .clear          (clear),
        .done           (done),
        .pass           (pass),
        .fail_idx       (fail_idx),
        .timeout        (timeout),
        .misaligned_err (misaligned_err),
        .cycle_count    (cycle_count)
    );

    typedef struct {
        bit          pass;
        bit          tmo;
        int unsigned fidx;
        int unsigned cycles;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_exp [N];
    logic [31:0] m_cap [N];
    bit          m_val [N];
    bit          m_idle, m_run, m_trig;
    int unsigned m_cycles;
    int unsigned vals [N] = '{3, 30, 2, 0, 7, 300};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_run) begin
            m_cycles++;
            if (m_trig || m_cycles >= TMO) m_run = 0;
        end
        m_trig = 0;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < N; i++) begin
            m_exp[i] = '0;
            m_cap[i] = '0;
            m_val[i] = 0;
        end
        m_idle = 1; m_run = 0; m_trig = 0; m_cycles = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        model_clear_all();
        rst_n = 1'b1;
    endtask

    task automatic program_exp(input int unsigned i, input logic [31:0] v);
        logic [IW-1:0] iw;
        iw = IW'(i);
        exp_wr_en = 1'b1; exp_wr_idx = iw; exp_wr_data = v;
        if (m_idle && i < N) m_exp[i] = v;
        tick();
        exp_wr_en = 1'b0;
    endtask

    task automatic program_all();
        for (int i = 0; i < N; i++) program_exp(i, vals[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_idle) begin
            m_idle = 0; m_run = 1; m_cycles = 0;
            for (int i = 0; i < N; i++) m_val[i] = 0;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_idle = 1; m_run = 0; m_cycles = 0;
        for (int i = 0; i < N; i++) m_val[i] = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        int  idx;
        bit  all;
        d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w;
        if (m_run && w != 4'b0) begin
            if (a >= BASE && a < BASE + 4 * N && a[1:0] == 2'b00) begin
                idx = int'((a - BASE) / 4);
                for (int k = 0; k < 4; k++)
                    if (w[k]) m_cap[idx][8*k +: 8] = d[8*k +: 8];
                m_val[idx] = 1;
            end
            if (a[31:2] == DADR[31:2]) m_trig = 1;
            all = 1;
            for (int i = 0; i < N; i++) if (!m_val[i]) all = 0;
            if (all) m_trig = 1;
        end
        tick();
        d_mem_wen = '0;
    endtask

    task automatic push_result();
        exp_t e;
        int   first;
        first = -1;
        for (int i = 0; i < N; i++)
            if (first < 0 && (!m_val[i] || m_cap[i] != m_exp[i])) first = i;
        e.tmo    = 0;
        e.pass   = (first < 0);
        e.fidx   = (first < 0) ? 0 : first;
        e.lat    = (first < 0) ? N : first + 1;
        e.cycles = m_cycles;
        sb.push_back(e);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.tmo = 1; e.pass = 0; e.fidx = 0; e.cycles = TMO; e.lat = -1;
        sb.push_back(e);
    endtask

    task automatic wait_compare(input string tag);
        exp_t e;
        int   cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".pass"}, 32'(pass), 32'(e.pass));
            chk({tag, ".timeout"}, 32'(timeout), 32'(e.tmo));
            chk({tag, ".fail_idx"}, 32'(fail_idx), e.fidx);
            chk({tag, ".cycle_count"}, 32'(cycle_count), e.cycles);
            if (e.lat >= 0) chk({tag, ".latency"}, cnt, e.lat);
        end
    endtask

    task automatic chk_idle_flags(input string tag);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
        chk({tag, ".fail_idx"}, 32'(fail_idx), 32'd0);
        chk({tag, ".misaligned"}, 32'(misaligned_err), 32'd0);
        chk({tag, ".cycle_count"}, 32'(cycle_count), 32'd0);
    endtask

    initial begin
        model_clear_all();
        tick();
        chk_idle_flags("reset");
        rst_n = 1'b1;
        tick();

        // Full-word pass, with ignored out-of-range and in-RUN expected writes
        program_all();
        program_exp(7, 32'hDEAD_BEEF);
        do_start();
        program_exp(1, 32'd999);
        for (int i = 0; i < N; i++) store(BASE + 4 * i, vals[i], 4'hF);
        push_result();
        wait_compare("pass_full");
        repeat (3) tick();
        chk("pass_hold", 32'(pass), 32'd1);

        // Mismatch at index 1
        do_clear();
        chk_idle_flags("clear1");
        do_start();
        for (int i = 0; i < N; i++) store(BASE + 4 * i, (i == 1) ? 32'd31 : vals[i], 4'hF);
        push_result();
        wait_compare("fail_idx1");

        // Byte-lane merge into a freshly reset word
        do_reset();
        program_all();
        do_start();
        store(BASE + 32'h14, 32'h0000_002C, 4'b0001);
        store(BASE + 32'h14, 32'h0000_0100, 4'b0010);
        for (int i = 0; i < N - 1; i++) store(BASE + 4 * i, vals[i], 4'hF);
        push_result();
        wait_compare("merge");

        // DONE_ADDR with missing entries
        do_clear();
        do_start();
        for (int i = 0; i < 4; i++) store(BASE + 4 * i, vals[i], 4'hF);
        store(DADR, 32'h1, 4'hF);
        push_result();
        wait_compare("done_addr");

        // Misaligned store then timeout
        do_clear();
        do_start();
        store(BASE + 32'h2, 32'hFFFF_FFFF, 4'b0001);
        chk("misaligned", 32'(misaligned_err), 32'd1);
        push_timeout();
        wait_compare("timeout");
        do_clear();
        chk_idle_flags("clear_after_tmo");

        // Last store coincides with the timeout cycle; cap[0] lane 0 must be untouched
        do_start();
        store(BASE, 32'h0, 4'b0010);
        for (int i = 1; i < N - 1; i++) store(BASE + 4 * i, vals[i], 4'hF);
        while (m_run && m_cycles < TMO - 1) tick();
        store(BASE + 4 * (N - 1), vals[N-1], 4'hF);
        push_result();
        wait_compare("race");

        // Asynchronous reset in the middle of CHECK
        do_clear();
        do_start();
        store(BASE + 32'h1, 32'h0, 4'hF);
        for (int i = 0; i < N; i++) store(BASE + 4 * i, vals[i], 4'hF);
        tick();
        tick();
        chk("pre_reset.misaligned", 32'(misaligned_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_flags("async_reset");
        tick();
        model_clear_all();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("no_partial.done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
Name: result_monitor

Overview:
- Synthesizable checker that watches the CPU data-memory write port (d_mem_addr / d_mem_wdata / d_mem_wen) and captures stores into a result window.
- Compares the captured results against a programmed expected table and reports pass, fail or timeout.
- Lets integration tests self-check in RTL instead of by testbench inspection of memory, and is reusable on FPGA with results driven to LEDs.

Parameters:
- BASE_ADDR, 32'h0000_0100, byte address of result word 0.
- NUM_RESULTS, 6, number of 32-bit result words, 1..32.
- DONE_ADDR, 32'h0000_0FFC, any write to this word forces an immediate check.
- TIMEOUT_CYCLES, 300, maximum RUN cycles before TIMEOUT, at least 1.
- IDX_W, $clog2(NUM_RESULTS) (minimum 1), index width.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- d_mem_addr, input, 32, CPU data address (snooped).
- d_mem_wdata, input, 32, CPU store data (snooped).
- d_mem_wen, input, 4, CPU byte-lane write enables; lane k covers bits 8k+7:8k.
- exp_wr_en, input, 1, write one expected-table entry.
- exp_wr_idx, input, IDX_W, expected-table index.
- exp_wr_data, input, 32, expected value.
- start, input, 1, pulse that moves IDLE to RUN.
- clear, input, 1, synchronous return to IDLE from any state.
- done, output, 1, high in PASS, FAIL and TIMEOUT.
- pass, output, 1, high only in PASS.
- fail_idx, output, IDX_W, first mismatching index; valid in FAIL.
- timeout, output, 1, high only in TIMEOUT.
- misaligned_err, output, 1, sticky; set by a non-word-aligned write inside the window.
- cycle_count, output, 16, RUN cycles elapsed; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Captured table, valid bits, expected table and counters cleared to 0.
- States: IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT.
- IDLE:
  - exp_wr_en=1 writes exp[exp_wr_idx] on the clock edge; an index >= NUM_RESULTS is ignored.
  - start=1 moves to RUN next cycle and zeroes cycle_count and the valid bits.
  - exp_wr_en is ignored in every state except IDLE.
- RUN, every cycle: cycle_count increments.
- RUN, capture of a write with d_mem_wen != 0 and BASE_ADDR <= addr < BASE_ADDR + 4*NUM_RESULTS:
  - addr[1:0] != 0: ignore the write, set misaligned_err.
  - Otherwise idx = (addr - BASE_ADDR) >> 2. Merge only the enabled byte lanes into cap[idx], keep the other lanes, and set valid[idx].
  - A repeat write to the same idx merges again; the last value wins per lane.
- RUN exits (capture of the current write happens first):
  - Leave for CHECK the cycle after all valid bits are set.
  - A write with d_mem_wen != 0 to DONE_ADDR moves to CHECK next cycle regardless of valid bits.
  - cycle_count reaching TIMEOUT_CYCLES moves to TIMEOUT, unless a CHECK trigger occurs in that same cycle; CHECK wins.
- CHECK, one index per cycle starting at 0:
  - Mismatch at the current index means cap[i] != exp[i] or valid[i] = 0.
  - First mismatch: latch fail_idx = i and go to FAIL next cycle.
  - If index NUM_RESULTS-1 matches, go to PASS next cycle.
  - Latency from CHECK entry to done: NUM_RESULTS cycles when all entries match.
- PASS / FAIL / TIMEOUT:
  - Hold until clear; start is ignored; CPU writes are not captured.
  - done, pass, timeout and fail_idx are registered and stable.
- clear, in any state:
  - Go to IDLE next cycle; zero valid bits, cycle_count, misaligned_err, fail_idx and the flags.
  - The expected table is kept; clear has priority over all other events.
- start and clear in the same cycle: clear wins.
- Reset asserted mid-RUN or mid-CHECK: immediate return to the reset state; no partial result is reported.

Decomposition:
- Shared include file holds:
  - state encoding defines (3-bit),
  - default BASE_ADDR / DONE_ADDR defines,
  - word-lane merge width constants.
- One natural sub-module, result_byte_merge: combinational per-lane merge of old word, new data and wen. It is instantiated once on the cap[idx] write path.
- Everything else is flat in result_monitor.

Test Plan:
- Program exp = {3,30,2,0,7,300}, start, full-word stores of the same values to 0x100..0x114 -> CHECK after the 6th store, done=1, pass=1 six cycles later.
- Same expected values, store 31 to 0x104 -> FAIL, fail_idx=1, pass=0.
- Store byte 0x2C with wen=4'b0001 to 0x114, then byte 0x01 with wen=4'b0010 to 0x114 -> cap[5]=300 (0x12C); merge passes.
- Store only to 0x100..0x10C, then write DONE_ADDR -> CHECK, FAIL with fail_idx=4 (invalid entry).
- Store to 0x102 -> misaligned_err=1 and cap unchanged. Then TIMEOUT_CYCLES=300 with no further writes -> timeout=1, done=1 at cycle_count=300. Then clear -> all flags 0, state IDLE.
- Last valid store and the timeout fall in the same cycle -> CHECK taken, timeout stays 0. Assert rst_n low during CHECK -> all outputs 0 asynchronously.
